// File: rtl/ram32x4_port_ctrl.sv
// ram32x4_port_ctrl: round-robin two-requester write arbiter and read-address sweeper for ram32x4.
// Optional CLEAR_ON_RESET_EN: zero-fill the whole RAM after reset before accepting requests.
module ram32x4_port_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int DIV    = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  input  logic              scan_hold,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              rd_strobe,
  output logic              busy
);
`ifdef CLEAR_ON_RESET_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  localparam int TW = $clog2(DIV);
  typedef enum logic {CLEAR, ARB} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] clr_q, wraddress_q, rdaddress_q;
  logic [DATA_W-1:0] data_q;
  logic [TW-1:0]     tick_q;
  logic              wren_q, ack0_q, ack1_q, last_grant_q, step_q, rd_strobe_q, busy_q;
  logic              e0, e1, g0, g1, tick_end;
  // a requester whose ack is still high is ignored so a late req drop cannot double-write
  assign e0 = req0 & ~ack0_q;
  assign e1 = req1 & ~ack1_q;
  assign g0 = e0 & (~e1 | last_grant_q);
  assign g1 = e1 & ~g0;
  assign tick_end = tick_q == TW'(DIV - 1);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= CLR_EN ? CLEAR : ARB;
      busy_q       <= CLR_EN;
      clr_q        <= '0;
      wren_q       <= 1'b0;
      wraddress_q  <= '0;
      data_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      last_grant_q <= 1'b1;
      tick_q       <= '0;
      rdaddress_q  <= '0;
      step_q       <= 1'b0;
      rd_strobe_q  <= 1'b0;
    end else begin
      step_q      <= ~scan_hold & tick_end;
      rd_strobe_q <= step_q;
      if (!scan_hold) begin
        tick_q <= tick_end ? '0 : tick_q + 1'b1;
        if (tick_end) rdaddress_q <= rdaddress_q + 1'b1;
      end
      busy_q <= CLR_EN && state_q == CLEAR;
      if (state_q == CLEAR) begin
        wren_q      <= 1'b1;
        wraddress_q <= clr_q;
        data_q      <= '0;
        ack0_q      <= 1'b0;
        ack1_q      <= 1'b0;
        clr_q       <= clr_q + 1'b1;
        if (&clr_q) state_q <= ARB;
      end else begin
        wren_q <= g0 | g1;
        ack0_q <= g0;
        ack1_q <= g1;
        if (g0 | g1) begin
          wraddress_q  <= g0 ? addr0 : addr1;
          data_q       <= g0 ? data0 : data1;
          last_grant_q <= g1;
        end
      end
    end
  end
  assign wren      = wren_q;
  assign wraddress = wraddress_q;
  assign data      = data_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdaddress = rdaddress_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_ram32x4_port_ctrl.sv
// tb_ram32x4_port_ctrl: directed bench with a cycle model of the arbiter/sweeper and a 32x4 RAM stand-in.
// Honours CLEAR_ON_RESET_EN the same way the design does.
module tb_ram32x4_port_ctrl;
  localparam int DIV = 4;
`ifdef CLEAR_ON_RESET_EN
  localparam int CLR_N = 32;
`else
  localparam int CLR_N = 0;
`endif
  logic       clock = 0, reset = 0, req0 = 0, req1 = 0, scan_hold = 0;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [3:0] data0 = 0, data1 = 0;
  logic       ack0, ack1, wren, rd_strobe, busy;
  logic [4:0] wraddress, rdaddress;
  logic [3:0] data, q;
  logic [3:0] ram [32];
  logic [3:0] exp_mem [32];
  int n_chk = 0, n_fail = 0;
  bit m_wren = 0, m_a0 = 0, m_a1 = 0, m_lg = 1, m_busy = 0, m_rs = 0, m_step = 0;
  int m_wa = 0, m_d = 0, m_left = 0, m_cnt = 0, exp_q = 0;

  ram32x4_port_ctrl #(.ADDR_W(5), .DATA_W(4), .DIV(DIV)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .scan_hold(scan_hold), .wren(wren), .wraddress(wraddress), .data(data),
    .rdaddress(rdaddress), .rd_strobe(rd_strobe), .busy(busy)
  );

  always #5 clock = ~clock;

  // RAM stand-in: registered read with old-data on same-address write
  always @(posedge clock) begin
    if (wren) ram[wraddress] <= data;
    q <= ram[rdaddress];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // behavioural model: sweep position derived from count of unheld cycles
  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_wren = 0; m_wa = 0; m_d = 0; m_a0 = 0; m_a1 = 0; m_lg = 1;
      m_left = CLR_N; m_busy = CLR_N > 0; m_cnt = 0; m_rs = 0; m_step = 0;
    end else begin
      bit e0, e1;
      int winner;
      exp_q = exp_mem[(m_cnt / DIV) % 32];
      if (m_wren) exp_mem[m_wa] = 4'(m_d);
      e0 = req0 && !m_a0;
      e1 = req1 && !m_a1;
      if (m_left > 0) begin
        m_wren = 1; m_wa = CLR_N - m_left; m_d = 0; m_a0 = 0; m_a1 = 0;
        m_left--; m_busy = 1;
      end else begin
        m_busy = 0;
        winner = (e0 && e1) ? (m_lg ? 0 : 1) : (e0 ? 0 : (e1 ? 1 : -1));
        m_a0 = winner == 0;
        m_a1 = winner == 1;
        m_wren = winner >= 0;
        if (winner == 0) begin m_wa = addr0; m_d = data0; m_lg = 0; end
        if (winner == 1) begin m_wa = addr1; m_d = data1; m_lg = 1; end
      end
      m_rs = m_step;
      m_step = 0;
      if (!scan_hold) begin
        m_cnt++;
        m_step = (m_cnt % DIV) == 0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("wren", wren, m_wren);
      if (m_wren) begin
        chk("wraddress", wraddress, m_wa);
        chk("data", data, m_d);
      end
      chk("ack0", ack0, m_a0);
      chk("ack1", ack1, m_a1);
      chk("ack_excl", ack0 && ack1, 0);
      chk("rdaddress", rdaddress, (m_cnt / DIV) % 32);
      chk("rd_strobe", rd_strobe, m_rs);
      chk("busy", busy, m_busy);
      if (rd_strobe && m_rs) chk("q", q, exp_q);
    end
  end

  task automatic reset_vals(input string tag);
    chk({tag, "_wren"}, wren, 0);
    chk({tag, "_wraddress"}, wraddress, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_ack0"}, ack0, 0);
    chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_rdaddress"}, rdaddress, 0);
    chk({tag, "_rd_strobe"}, rd_strobe, 0);
    chk({tag, "_busy"}, busy, CLR_N > 0);
  endtask

  initial begin
    int nw, k, prev, nstrobe, last_t, cyc;
    bit wrapped, seen;
    for (int i = 0; i < 32; i++) begin ram[i] = 0; exp_mem[i] = 0; end
    #12;
    reset_vals("rst");
    @(negedge clock) reset = 1;
`ifdef CLEAR_ON_RESET_EN
    req0 = 1; addr0 = 2; data0 = 3;
    nw = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clock);
      if (busy && wren) begin chk("clr_addr", wraddress, nw); chk("clr_data", data, 0); nw++; end
      if (busy) chk("clr_no_ack", ack0, 0);
      else begin seen = 1; chk("ack_after_clear", ack0, 1); end
    end
    chk("clr_writes", nw, 32);
    chk("clr_done", seen, 1);
    req0 = 0;
    @(negedge clock);
`else
    chk("busy_tied0", busy, 0);
`endif
    req0 = 1; addr0 = 5; data0 = 4'hA;
    @(negedge clock);
    chk("t1_wren", wren, 1);
    chk("t1_wraddress", wraddress, 5);
    chk("t1_data", data, 4'hA);
    chk("t1_ack0", ack0, 1);
    chk("t1_ack1", ack1, 0);
    @(negedge clock);
    chk("t1_no_rewrite", wren, 0);
    chk("t1_ack0_low", ack0, 0);
    req0 = 0;
    for (int i = 0; i < 32; i++) begin
      req1 = 1; addr1 = 5'(i); data1 = 4'(i);
      k = 0;
      do begin @(negedge clock); k++; end while (!ack1 && k < 4);
      chk("fill_ack", ack1, 1);
      chk("fill_addr", wraddress, i);
    end
    req1 = 0;
    repeat (2) @(negedge clock);
    nstrobe = 0; prev = 0; wrapped = 0; last_t = 0;
    for (int c = 0; c < 136; c++) begin
      @(negedge clock);
      if (rd_strobe) begin
        chk("sweep_q", q, rdaddress[3:0]);
        if (nstrobe > 0) begin
          chk("sweep_step", rdaddress, (prev + 1) % 32);
          chk("sweep_period", c - last_t, DIV);
        end
        if (prev == 31 && rdaddress == 0) wrapped = 1;
        prev = rdaddress; last_t = c; nstrobe++;
      end
    end
    chk("sweep_count", nstrobe >= 32, 1);
    chk("sweep_wrap", wrapped, 1);
    k = 0;
    do begin @(negedge clock); k++; end while (!(rd_strobe && rdaddress == 9) && k < 200);
    chk("hold_reach9", rdaddress, 9);
    scan_hold = 1;
    repeat (10) begin
      @(negedge clock);
      chk("hold_addr", rdaddress, 9);
      chk("hold_strobe", rd_strobe, 0);
    end
    scan_hold = 0;
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (rdaddress != 10 && cyc < 8);
    chk("hold_resume_cycles", cyc, 3);
    req0 = 1; addr0 = 3; data0 = 4'hD;
    req1 = 1; addr1 = 7; data1 = 4'hE;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #3 reset = 0;
    #1 reset_vals("async");
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    k = 0;
    while (busy && k < 40) begin @(negedge clock); k++; end
    chk("busy_released", busy, 0);
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rr_ack0", ack0, i % 2 == 0);
      chk("rr_ack1", ack1, i % 2 == 1);
      chk("rr_addr", wraddress, i % 2 == 0 ? 3 : 7);
      chk("rr_data", data, i % 2 == 0 ? 4'hD : 4'hE);
    end
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
